// File: rtl/traffic_fsm.sv
// Two-street traffic light controller driving an external interval timer.
// Latency: one core cycle from a qualified expired to the new state and its start_timer pulse.
// Backpressure: none; expired is ignored until two cycles after each start_timer pulse.
module traffic_fsm #(
    parameter logic [3:0] T_BASE = 4'd6,
    parameter logic [3:0] T_EXT  = 4'd3,
    parameter logic [3:0] T_YEL  = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Sensor,
    input  logic       Walk_Request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] Value,
    output logic [2:0] Main_Lights,
    output logic [2:0] Side_Lights,
    output logic       Walk_Lamp
);

    typedef enum logic [2:0] {
        ST_MG1  = 3'd0,
        ST_MG2  = 3'd1,
        ST_MY   = 3'd2,
        ST_WALK = 3'd3,
        ST_SG   = 3'd4,
        ST_SGX  = 3'd5,
        ST_SY   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic       boot_q;
    logic       start_q, start_d;
    logic [1:0] cnt_q, cnt_d;
    logic       walk_pend_q, walk_pend_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_lamp_q, walk_lamp_d;
    logic [3:0] value_q, value_d;
    logic       qualify;

    // cnt_q saturates at 2, so a stale expired from the previous interval is masked
    assign qualify = !start_q && (cnt_q == 2'd2) && expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MG1;
            boot_q      <= 1'b1;
            start_q     <= 1'b0;
            cnt_q       <= 2'd0;
            walk_pend_q <= 1'b0;
            main_q      <= 3'b001;
            side_q      <= 3'b100;
            walk_lamp_q <= 1'b0;
            value_q     <= T_BASE;
        end else begin
            state_q     <= state_d;
            boot_q      <= 1'b0;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            walk_pend_q <= walk_pend_d;
            main_q      <= main_d;
            side_q      <= side_d;
            walk_lamp_q <= walk_lamp_d;
            value_q     <= value_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = boot_q || qualify;
        walk_pend_d = walk_pend_q;
        if (Walk_Request && (state_q != ST_WALK)) walk_pend_d = 1'b1;
        case (state_q)
            ST_MG1:  if (qualify) state_d = Sensor ? ST_MY : ST_MG2;
            ST_MG2:  if (qualify) state_d = ST_MY;
            ST_MY:   if (qualify) state_d = walk_pend_d ? ST_WALK : ST_SG;
            ST_WALK: begin
                if (qualify) begin
                    state_d     = ST_SG;
                    walk_pend_d = 1'b0;
                end
            end
            ST_SG:   if (qualify) state_d = Sensor ? ST_SGX : ST_SY;
            ST_SGX:  if (qualify) state_d = ST_SY;
            ST_SY:   if (qualify) state_d = ST_MG1;
            default: begin
                state_d = ST_MG1;
                start_d = 1'b1;
            end
        endcase
        cnt_d = start_d ? 2'd0 : ((cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1);
    end

    // Outputs decode the next state so lamps and Value change with the start pulse
    always_comb begin
        main_d      = 3'b001;
        side_d      = 3'b100;
        walk_lamp_d = 1'b0;
        value_d     = T_BASE;
        case (state_d)
            ST_MY: begin
                main_d  = 3'b010;
                value_d = T_YEL;
            end
            ST_WALK: begin
                main_d      = 3'b100;
                walk_lamp_d = 1'b1;
                value_d     = T_EXT;
            end
            ST_SG: begin
                main_d = 3'b100;
                side_d = 3'b001;
            end
            ST_SGX: begin
                main_d  = 3'b100;
                side_d  = 3'b001;
                value_d = T_EXT;
            end
            ST_SY: begin
                main_d  = 3'b100;
                side_d  = 3'b010;
                value_d = T_YEL;
            end
            default: begin
                main_d  = 3'b001;
                side_d  = 3'b100;
                value_d = T_BASE;
            end
        endcase
    end

    assign start_timer = start_q;
    assign Value       = value_q;
    assign Main_Lights = main_q;
    assign Side_Lights = side_q;
    assign Walk_Lamp   = walk_lamp_q;

endmodule
